// File: rtl/img_win_ctrl.sv
// 2x2 image window controller: loads an image from ROM, edits a movable 2x2
// window in place on command, and streams the whole image out to RAM.
module img_win_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 2);
  localparam logic [RW-1:0] ROW_RST = RW'(IMG_H / 2 - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 2);
  localparam logic [CW-1:0] COL_RST = CW'(IMG_W / 2 - 1);

  typedef enum logic [2:0] {LOAD, CMD, OP, WRITE, FIN} state_t;

  state_t        state;
  logic [3:0]    op;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] buffer [N];

  logic [AW-1:0] a_tl, a_tr, a_bl, a_br, wr_next;
  logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic [DW-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn;
  logic [DW+1:0] sum;
  logic          win_we;

  always_comb begin
    a_tl    = AW'(int'(row) * IMG_W + int'(col));
    a_tr    = a_tl + AW'(1);
    a_bl    = a_tl + AW'(IMG_W);
    a_br    = a_bl + AW'(1);
    wr_next = IRAM_A + AW'(1);
    p_tl    = buffer[a_tl];
    p_tr    = buffer[a_tr];
    p_bl    = buffer[a_bl];
    p_br    = buffer[a_br];
    mx_t    = (p_tl > p_tr) ? p_tl : p_tr;
    mx_b    = (p_bl > p_br) ? p_bl : p_br;
    mx      = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t    = (p_tl < p_tr) ? p_tl : p_tr;
    mn_b    = (p_bl < p_br) ? p_bl : p_br;
    mn      = (mn_t < mn_b) ? mn_t : mn_b;
    sum     = (DW+2)'(p_tl) + (DW+2)'(p_tr) + (DW+2)'(p_bl) + (DW+2)'(p_br);
  end

  // New window contents for the pixel-editing commands; all outputs are
  // taken from the pre-command pixels so swaps and rotations need no temps.
  always_comb begin
    n_tl   = p_tl;
    n_tr   = p_tr;
    n_bl   = p_bl;
    n_br   = p_br;
    win_we = 1'b1;
    case (op)
      4'd5:  begin n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
      4'd6:  begin n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
      4'd7:  begin
        n_tl = DW'(sum >> 2); n_tr = DW'(sum >> 2);
        n_bl = DW'(sum >> 2); n_br = DW'(sum >> 2);
      end
      4'd8:  begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
      4'd9:  begin n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
      4'd10: begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
      4'd11: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
      4'd12: begin n_tl = ~p_tl; n_tr = ~p_tr; n_bl = ~p_bl; n_br = ~p_br; end
      default: win_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      buffer[IROM_A] <= IROM_Q;
    end else if (state == OP && win_we) begin
      buffer[a_tl] <= n_tl;
      buffer[a_tr] <= n_tr;
      buffer[a_bl] <= n_bl;
      buffer[a_br] <= n_br;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      op         <= '0;
      row        <= ROW_RST;
      col        <= COL_RST;
      IROM_rd    <= 1'b1;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (IROM_A == LAST) begin
            state   <= CMD;
            IROM_rd <= 1'b0;
            IROM_A  <= '0;
            busy    <= 1'b0;
          end else begin
            IROM_A <= IROM_A + AW'(1);
          end
        end
        CMD: begin
          if (cmd_valid) begin
            busy <= 1'b1;
            op   <= cmd;
            if (cmd == 4'd0) begin
              state      <= WRITE;
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= buffer[0];
            end else begin
              state <= OP;
            end
          end
        end
        OP: begin
          if (op == 4'd13) begin
            state   <= LOAD;
            IROM_rd <= 1'b1;
            IROM_A  <= '0;
          end else begin
            state <= CMD;
            busy  <= 1'b0;
            case (op)
              4'd1: if (row != '0)     row <= row - RW'(1);
              4'd2: if (row < ROW_MAX) row <= row + RW'(1);
              4'd3: if (col != '0)     col <= col - CW'(1);
              4'd4: if (col < COL_MAX) col <= col + CW'(1);
              default: ;
            endcase
          end
        end
        WRITE: begin
          if (IRAM_A == LAST) begin
            state      <= FIN;
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            IRAM_A <= wr_next;
            IRAM_D <= buffer[wr_next];
          end
        end
        FIN: begin
          state <= CMD;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Bench for img_win_ctrl: a transaction-level image model predicts every
// output cycle; directed cases pin the model, then random commands follow.
module tb_img_win_ctrl;

  localparam int DW = 8, W = 8, H = 8, AW = 6, N = 64;
  localparam int DW2 = 10, W2 = 16, H2 = 4, N2 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cmd_valid, IROM_rd, IRAM_valid, busy, done;
  logic [3:0]    cmd;
  logic [DW-1:0] IROM_Q, IRAM_D;
  logic [AW-1:0] IROM_A, IRAM_A;
  logic [DW-1:0] rom [N];
  assign IROM_Q = rom[IROM_A];

  logic           reset2, cmd_valid2, IROM_rd2, IRAM_valid2, busy2, done2;
  logic [3:0]     cmd2;
  logic [DW2-1:0] IROM_Q2, IRAM_D2;
  logic [AW-1:0]  IROM_A2, IRAM_A2;
  logic [DW2-1:0] rom2 [N2];
  assign IROM_Q2 = rom2[IROM_A2];

  img_win_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H), .AW(AW)) u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done));

  img_win_ctrl #(.DW(DW2), .IMG_W(W2), .IMG_H(H2), .AW(AW)) u_dut2 (
    .clk(clk), .reset(reset2), .cmd(cmd2), .cmd_valid(cmd_valid2), .IROM_Q(IROM_Q2),
    .IROM_rd(IROM_rd2), .IROM_A(IROM_A2), .IRAM_valid(IRAM_valid2), .IRAM_D(IRAM_D2),
    .IRAM_A(IRAM_A2), .busy(busy2), .done(done2));

  int img [N];
  int row_m, col_m;
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  logic e_busy, e_rd, e_valid, e_done, e_rst;
  int e_irom_a, e_iram_a, e_iram_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("IROM_rd", 32'(IROM_rd), 32'(e_rd));
      chk("IRAM_valid", 32'(IRAM_valid), 32'(e_valid));
      chk("done", 32'(done), 32'(e_done));
      if (e_rd) chk("IROM_A", 32'(IROM_A), e_irom_a);
      if (e_valid || e_rst) begin
        chk("IRAM_A", 32'(IRAM_A), e_iram_a);
        chk("IRAM_D", 32'(IRAM_D), e_iram_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic r, input logic v, input logic d);
    e_busy = b; e_rd = r; e_valid = v; e_done = d; e_rst = 1'b0;
  endtask

  task automatic set_rst();
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    e_rst = 1'b1; e_irom_a = 0; e_iram_a = 0; e_iram_d = 0;
  endtask

  task automatic idle();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
  endtask

  task automatic load_seq();
    for (int i = 0; i < N; i++) begin
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
      e_irom_a = i;
      tick();
    end
    for (int i = 0; i < N; i++) img[i] = int'(rom[i]);
  endtask

  // abort_at >= 0 asserts reset at the start of that write cycle
  task automatic write_seq(input int abort_at);
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        set_rst();
        return;
      end
      set_exp(1'b1, 1'b0, 1'b1, 1'b0);
      e_iram_a = i;
      e_iram_d = img[i];
      cmd_valid = 1'($urandom_range(0, 1));
      cmd = 4'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic model_op(input int c);
    int a[4], p[4], q[4];
    int t;
    a[0] = row_m * W + col_m; a[1] = a[0] + 1; a[2] = a[0] + W; a[3] = a[2] + 1;
    for (int k = 0; k < 4; k++) p[k] = img[a[k]];
    q = p;
    case (c)
      1: if (row_m > 0) row_m--;
      2: if (row_m < H - 2) row_m++;
      3: if (col_m > 0) col_m--;
      4: if (col_m < W - 2) col_m++;
      5: begin t = 0; for (int k = 0; k < 4; k++) if (p[k] > t) t = p[k]; q = '{t, t, t, t}; end
      6: begin t = 255; for (int k = 0; k < 4; k++) if (p[k] < t) t = p[k]; q = '{t, t, t, t}; end
      7: begin t = (p[0] + p[1] + p[2] + p[3]) / 4; q = '{t, t, t, t}; end
      8: q = '{p[1], p[3], p[0], p[2]};
      9: q = '{p[2], p[0], p[3], p[1]};
      10: q = '{p[2], p[3], p[0], p[1]};
      11: q = '{p[1], p[0], p[3], p[2]};
      12: for (int k = 0; k < 4; k++) q[k] = (1 << DW) - 1 - p[k];
      default: ;
    endcase
    for (int k = 0; k < 4; k++) img[a[k]] = q[k];
  endtask

  task automatic do_cmd(input int c, input int gap, input bit noise);
    repeat (gap) begin idle(); tick(); end
    idle();
    cmd = 4'(c);
    cmd_valid = 1'b1;
    tick();
    if (c == 0) begin
      write_seq(-1);
    end else begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      if (c != 13) model_op(c);
      cmd_valid = noise;
      cmd = 4'($urandom);
      tick();
      cmd_valid = 1'b0;
      if (c == 13) load_seq();
    end
    idle();
  endtask

  initial begin
    int t, cnt, c;
    int exp2 [N2];
    reset = 1'b0; reset2 = 1'b0; cmd = '0; cmd_valid = 1'b0; cmd2 = '0; cmd_valid2 = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    row_m = 3; col_m = 3;
    #2;
    set_rst();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    load_seq();
    idle();
    do_cmd(0, 1, 1'b0);

    do_cmd(7, 0, 1'b1);
    chk("avg_pin27", img[27], 31);
    chk("avg_pin36", img[36], 31);
    do_cmd(0, 0, 1'b0);

    repeat (5) do_cmd(1, 0, 1'b1);
    chk("row_sat", row_m, 0);
    repeat (9) do_cmd(4, 1, 1'b0);
    chk("col_sat", col_m, 6);
    do_cmd(12, 0, 1'b0);
    do_cmd(0, 0, 1'b0);

    for (int i = 0; i < N; i++) rom[i] = DW'(i * 7 + 3);
    rom[6] = 8'd10; rom[7] = 8'd20; rom[14] = 8'd30; rom[15] = 8'd40;
    do_cmd(13, 0, 1'b1);
    chk("reload_row", row_m, 0);
    do_cmd(8, 0, 1'b0);
    chk("ccw_tl", img[6], 20);
    chk("ccw_tr", img[7], 40);
    chk("ccw_bl", img[14], 10);
    chk("ccw_br", img[15], 30);
    do_cmd(0, 0, 1'b0);
    do_cmd(13, 2, 1'b0);
    do_cmd(12, 0, 1'b0);
    chk("inv_tl", img[6], 245);
    chk("inv_br", img[15], 215);
    do_cmd(0, 0, 1'b0);

    idle();
    cmd = 4'd0; cmd_valid = 1'b1;
    tick();
    write_seq(20);
    tick(); tick();
    reset = 1'b1;
    row_m = 3; col_m = 3;
    load_seq();
    idle();
    do_cmd(9, 0, 1'b0);
    do_cmd(0, 0, 1'b0);

    for (int i = 0; i < N; i++) rom[i] = DW'($urandom);
    do_cmd(13, 0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      c = $urandom_range(1, 15);
      if ($urandom_range(0, 4) == 0) c = 0;
      if (c == 13) for (int i = 0; i < N; i++) rom[i] = DW'($urandom);
      do_cmd(c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    do_cmd(0, 0, 1'b0);
    chk_en = 1'b0;

    for (int i = 0; i < N2; i++) rom2[i] = DW2'(i);
    rom2[23] = 10'd1023; rom2[24] = 10'd0; rom2[39] = 10'd5; rom2[40] = 10'd7;
    for (int i = 0; i < N2; i++) exp2[i] = int'(rom2[i]);
    exp2[23] = 1023; exp2[24] = 1023; exp2[39] = 1023; exp2[40] = 1023;
    tick();
    reset2 = 1'b1;
    t = 0;
    while (busy2 && t < 200) begin tick(); t++; end
    chk("dut2_load_cycles", t, 64);
    cmd2 = 4'd5; cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    tick();
    chk("dut2_busy_after_op", 32'(busy2), 0);
    cmd2 = 4'd0; cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    cnt = 0; t = 0;
    while (!done2 && t < 200) begin
      if (IRAM_valid2) begin
        chk("dut2_addr", 32'(IRAM_A2), cnt);
        chk("dut2_data", 32'(IRAM_D2), (cnt < N2) ? exp2[cnt] : -1);
        cnt++;
      end
      tick();
      t++;
    end
    chk("dut2_writes", cnt, 64);
    chk("dut2_done", 32'(done2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/img_win_ctrl.md
IMG_WIN_CTRL -- requirements
Module: img_win_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 8, meaning image columns (even, >=4).
REQ-003 SHALL have parameter IMG_H, default 8, meaning image rows (even, >=4).
REQ-004 SHALL have parameter AW, default 6, meaning address width, equal to clog2(IMG_W*IMG_H).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port cmd, input, 4, command code.
REQ-008 SHALL have port cmd_valid, input, 1, cmd qualifier.
REQ-009 SHALL have port IROM_Q, input, DW, ROM read data, combinational from IROM_A.
REQ-010 SHALL have port IROM_rd, output, 1, ROM read enable.
REQ-011 SHALL have port IROM_A, output, AW, ROM address.
REQ-012 SHALL have port IRAM_valid, output, 1, RAM write strobe.
REQ-013 SHALL have port IRAM_D, output, DW, RAM write data.
REQ-014 SHALL have port IRAM_A, output, AW, RAM write address.
REQ-015 SHALL have port busy, output, 1, high when cmd is not accepted.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at end of each write-out.

Function
REQ-017 SHALL implement states LOAD, CMD, OP, WRITE, FIN; N = IMG_W*IMG_H.
REQ-018 SHALL, in LOAD, drive IROM_rd=1 and busy=1, step IROM_A 0..N-1 one per cycle, and store IROM_Q into buffer[IROM_A] each cycle.
REQ-019 SHALL leave LOAD for CMD on the cycle after address N-1 is captured; IROM_rd=0 from then on.
REQ-020 SHALL keep window origin as (row,col), reset value (IMG_H/2-1, IMG_W/2-1); window = 2x2 pixels at origin, origin+1, origin+IMG_W, origin+IMG_W+1.
REQ-021 SHALL, in CMD, drive busy=0; when cmd_valid=1, register cmd and go to OP (cmd 0 goes to WRITE); cmd_valid while busy=1 is ignored.
REQ-022 SHALL execute every non-write command in OP in exactly one cycle with busy=1, then return to CMD (busy high exactly one cycle per command).
REQ-023 SHALL decode cmd: 1 up, 2 down, 3 left, 4 right; each saturates with row in [0,IMG_H-2], col in [0,IMG_W-2]; at a limit the origin is unchanged.
REQ-024 SHALL decode cmd 5 MAX / 6 MIN: all four window pixels take the unsigned max / min of the window.
REQ-025 SHALL decode cmd 7 AVG: all four window pixels take floor(sum/4), with sum computed at DW+2 bits (no overflow).
REQ-026 SHALL decode cmd 8 CCW rotate (TL<-TR, TR<-BR, BR<-BL, BL<-TL) and cmd 9 CW rotate (TL<-BL, BL<-BR, BR<-TR, TR<-TL).
REQ-027 SHALL decode cmd 10 mirror-X (swap rows) and cmd 11 mirror-Y (swap columns), using pre-command values for all four pixels.
REQ-028 SHALL decode cmd 12 INV: each window pixel becomes (2^DW-1) minus the pixel.
REQ-029 SHALL decode cmd 13 RELOAD: return to LOAD from address 0, origin unchanged.
REQ-030 SHALL treat cmd 14 and 15 as no-ops that still take one busy OP cycle.
REQ-031 SHALL, in WRITE, drive busy=1 and IRAM_valid=1 for exactly N cycles with IRAM_A 0..N-1 and IRAM_D=buffer[IRAM_A] in the same cycle.
REQ-032 SHALL enter FIN after the last write: IRAM_valid=0, busy=1, done=1 for one cycle, then return to CMD; repeated write-outs are allowed.
REQ-033 SHALL hold done=0 in all states except FIN.

Reset
REQ-034 SHALL, while reset=0: state LOAD, IROM_A=0, IRAM_A=0, IRAM_D=0, origin at reset value, done=0, IRAM_valid=0, busy=1, IROM_rd=1 after release; buffer contents need no reset.
REQ-035 SHALL abort any LOAD, OP or WRITE on reset assertion; the next load restarts at address 0.

Verification
REQ-036 SHALL cover default params, ROM[i]=i, reset release -> IROM_A 0..63 over 64 cycles, busy falls the cycle after, then cmd 0 -> IRAM writes 0..63 in order, done pulses once.
REQ-037 SHALL cover origin (3,3), cmd 7 with window 27,28,35,36 -> addresses 27,28,35,36 all read 31.
REQ-038 SHALL cover 5x cmd 1 from reset -> origin row 0 (saturated); then 9x cmd 4 -> col 6.
REQ-039 SHALL cover window 10,20,30,40 (TL,TR,BL,BR) -> cmd 8 gives 20,40,10,30; cmd 12 (from original) gives 245,235,225,215.
REQ-040 SHALL cover IMG_W=16, IMG_H=4, DW=10, AW=6: cmd 5 on window {1023,0,5,7} -> all 1023; write-out covers 64 addresses.
REQ-041 SHALL cover reset=0 asserted mid-WRITE at IRAM_A=20 -> outputs at reset values immediately; LOAD restarts at 0; cmd 13 mid-session reloads ROM with origin kept.
